// File: rtl/pipe_addsub.sv
// pipe_addsub: carry-pipelined add/subtract, one SEG-bit segment per stage,
// with valid/ready flow control and registered sum/carry/overflow/zero/neg flags.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int SEG = WIDTH / STAGES;
    localparam int L   = STAGES - 1;
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             z_q   [STAGES];
    logic             src_v [STAGES];
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_z [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic [SEG:0]     seg_sum [STAGES];
    logic             ovf_q;
    logic             ovf_n;
    logic             advance;
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[L];
    assign sum       = s_q[L];
    assign cout      = c_q[L];
    assign zero      = z_q[L];
    assign ovf       = ovf_q;
    assign neg       = sum[WIDTH-1];
    // Stage k reads the register of stage k-1; stage 0 reads the ports directly.
    always_comb begin
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_s[0] = '0;
        src_c[0] = cin;
        src_z[0] = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            src_z[k] = z_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_sum[k] = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, src_c[k]};
            nxt_s[k] = src_s[k];
            nxt_s[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
        end
        ovf_n = (src_a[L][WIDTH-1] == src_b[L][WIDTH-1]) && (nxt_s[L][WIDTH-1] != src_a[L][WIDTH-1]);
    end
    // Data registers load only for valid entries so a bubble never disturbs held outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                z_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= src_v[k];
                if (src_v[k]) begin
                    a_q[k] <= src_a[k];
                    b_q[k] <= src_b[k];
                    s_q[k] <= nxt_s[k];
                    c_q[k] <= seg_sum[k][SEG];
                    z_q[k] <= src_z[k] && (seg_sum[k][SEG-1:0] == '0);
                end
            end
            if (src_v[L]) ovf_q <= ovf_n;
        end
    end
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: randomized and directed checks of pipe_addsub against an
// arithmetic reference model, plus latency/wrap checks for other parameter sets.
module tb_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1, sub = 1'b0, cin = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf, zero, neg;
    logic [31:0] sum;
    logic        sw_valid = 1'b0;
    logic [31:0] w1_a = '0, w1_b = '0, w1_sum;
    logic [7:0]  w8_a = '0, w8_b = '0, w8_sum;
    logic [63:0] w64_a = '0, w64_b = '0, w64_sum;
    logic        w1_ir, w1_ov, w1_cout, w1_ovf, w1_zero, w1_neg;
    logic        w8_ir, w8_ov, w8_cout, w8_ovf, w8_zero, w8_neg;
    logic        w64_ir, w64_ov, w64_cout, w64_ovf, w64_zero, w64_neg;
    int          checks = 0, fails = 0;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero), .neg(neg));
    pipe_addsub #(.WIDTH(32), .STAGES(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(w1_ir), .a(w1_a), .b(w1_b),
        .sub(1'b0), .cin(1'b0), .out_valid(w1_ov), .out_ready(1'b1), .sum(w1_sum),
        .cout(w1_cout), .ovf(w1_ovf), .zero(w1_zero), .neg(w1_neg));
    pipe_addsub #(.WIDTH(8), .STAGES(8)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(w8_ir), .a(w8_a), .b(w8_b),
        .sub(1'b0), .cin(1'b0), .out_valid(w8_ov), .out_ready(1'b1), .sum(w8_sum),
        .cout(w8_cout), .ovf(w8_ovf), .zero(w8_zero), .neg(w8_neg));
    pipe_addsub #(.WIDTH(64), .STAGES(2)) dut_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(w64_ir), .a(w64_a), .b(w64_b),
        .sub(1'b0), .cin(1'b0), .out_valid(w64_ov), .out_ready(1'b1), .sum(w64_sum),
        .cout(w64_cout), .ovf(w64_ovf), .zero(w64_zero), .neg(w64_neg));

    // Reference: {ovf,neg,zero,cout,sum} from plain unsigned and signed arithmetic.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input logic c);
        logic [31:0] yx;
        logic [32:0] u;
        longint      r;
        yx = s ? ~y : y;
        u  = 33'(x) + 33'(yx) + 33'(c);
        r  = longint'($signed(x)) + longint'($signed(yx)) + longint'(c);
        return {(r > 64'sd2147483647) || (r < -64'sd2147483648), u[31], u[31:0] == 32'h0, u[32], u[31:0]};
    endfunction

    function automatic logic [35:0] outs();
        return {ovf, neg, zero, cout, sum};
    endfunction

    task automatic send_wait(input logic [31:0] x, input logic [31:0] y, input logic s,
                             input logic c, output int lat, output logic [35:0] got);
        @(posedge clk); #1;
        a = x; b = y; sub = s; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = outs();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, w1_ov, w8_ov, w64_ov} !== 4'b0)
            $display("FAIL reset_valid: got %b required 0000", {out_valid, w1_ov, w8_ov, w64_ov});
        checks++;
        if (outs() !== 36'h0) $display("FAIL reset_outputs: got %h required 0", outs());
        if (outs() !== 36'h0) fails++;
        if ({out_valid, w1_ov, w8_ov, w64_ov} !== 4'b0) fails++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_directed;
        logic [31:0] va [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7};
        logic [31:0] vb [4] = '{32'd1, 32'd1, 32'd7, 32'd5};
        logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [35:0] ve [4] = '{36'h3_0000_0000, 36'hC_8000_0000, 36'h4_FFFF_FFFE, 36'h1_0000_0001};
        int          lat;
        logic [35:0] got;
        for (int i = 0; i < 4; i++) begin
            send_wait(va[i], vb[i], vs[i], vc[i], lat, got);
            checks++;
            if (lat != 4) begin
                fails++;
                $display("FAIL directed_latency[%0d]: got %0d cycles required 4", i, lat);
            end
            checks++;
            if (got !== ve[i]) begin
                fails++;
                $display("FAIL directed_result[%0d]: got {ovf,neg,zero,cout,sum}=%h required %h", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [35:0] exp_q[$];
        logic [31:0] ta, tb2;
        logic        ts, tc, held;
        logic [36:0] hold_val;
        int          sent = 0, got = 0, cyc = 0;
        ta = $urandom; tb2 = $urandom; ts = 1'(($urandom)); tc = 1'(($urandom));
        held = 1'b0; hold_val = '0;
        @(posedge clk); #1;
        while ((sent < 16 || got < 16) && cyc < 400) begin
            in_valid = (sent < 16);
            a = ta; b = tb2; sub = ts; cin = tc;
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (held) begin
                checks++;
                if ({out_valid, outs()} !== hold_val) begin
                    fails++;
                    $display("FAIL stream_stall_stable: got %h required %h", {out_valid, outs()}, hold_val);
                end
            end
            held = out_valid && !out_ready;
            hold_val = {out_valid, outs()};
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0 || outs() !== exp_q[0]) begin
                    fails++;
                    $display("FAIL stream_result[%0d]: got %h required %h", got, outs(),
                             exp_q.size() ? exp_q[0] : 36'h0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ta, tb2, ts, tc));
                sent++;
                ta = $urandom; tb2 = $urandom; ts = 1'(($urandom)); tc = 1'(($urandom));
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != 16 || exp_q.size() != 0 || cyc >= 400) begin
            fails++;
            $display("FAIL stream_count: got %0d results, %0d pending, %0d cycles; required 16, 0, <400", got, exp_q.size(), cyc);
        end
    endtask

    task automatic test_full;
        int c = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        a = $urandom; b = $urandom; sub = 1'b0; cin = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            fails++;
            $display("FAIL full_backpressure: got out_valid,in_ready=%b required 10", {out_valid, in_ready});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        while (out_valid && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (c != 4) begin
            fails++;
            $display("FAIL full_drain: got %0d pops required 4", c);
        end
    endtask

    task automatic test_reset_mid;
        int stale = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, outs()} !== 37'h0) begin
            fails++;
            $display("FAIL midreset_immediate: got %h required 0", {out_valid, outs()});
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            fails++;
            $display("FAIL midreset_stale: got %0d valid cycles required 0", stale);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_sweep;
        int          l1 = 0, l8 = 0, l64 = 0;
        logic [35:0] g1 = '0;
        logic [11:0] g8 = '0;
        logic [67:0] g64 = '0;
        @(posedge clk); #1;
        w1_a = '1; w1_b = 32'd1; w8_a = '1; w8_b = 8'd1; w64_a = '1; w64_b = 64'd1;
        sw_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            sw_valid = 1'b0;
            if (w1_ov && l1 == 0) begin l1 = c; g1 = {w1_ovf, w1_neg, w1_zero, w1_cout, w1_sum}; end
            if (w8_ov && l8 == 0) begin l8 = c; g8 = {w8_ovf, w8_neg, w8_zero, w8_cout, w8_sum}; end
            if (w64_ov && l64 == 0) begin l64 = c; g64 = {w64_ovf, w64_neg, w64_zero, w64_cout, w64_sum}; end
        end
        checks++;
        if (l1 != 1) begin fails++; $display("FAIL sweep_w32s1_latency: got %0d required 1", l1); end
        checks++;
        if (l8 != 8) begin fails++; $display("FAIL sweep_w8s8_latency: got %0d required 8", l8); end
        checks++;
        if (l64 != 2) begin fails++; $display("FAIL sweep_w64s2_latency: got %0d required 2", l64); end
        checks++;
        if (g1 !== {4'h3, 32'h0}) begin fails++; $display("FAIL sweep_w32s1_wrap: got %h required 300000000", g1); end
        checks++;
        if (g8 !== {4'h3, 8'h0}) begin fails++; $display("FAIL sweep_w8s8_wrap: got %h required 300", g8); end
        checks++;
        if (g64 !== {4'h3, 64'h0}) begin fails++; $display("FAIL sweep_w64s2_wrap: got %h required 30000000000000000", g64); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
